// File: rtl/iob_cpu_bus_demux.sv
// Purpose : routes one CPU native memory request to one of N_SLAVES ports chosen by address MSBs.
// Latency : m_ready arrives 2 cycles after capture for a zero-wait slave, plus 1 per slave wait cycle.
// Backpres: the master holds its request until m_ready; a silent slave is abandoned after TIMEOUT cycles.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   boot                          remaps slave 0 to BOOT_SEL, sampled at request capture
//   m_valid/m_addr/m_wdata/m_wstrb CPU request (wstrb all zero = read)
//   m_rdata/m_ready               registered read data and one-cycle completion pulse
//   s_valid                       one-hot slave request
//   s_addr/s_wdata/s_wstrb        latched request, broadcast to all slaves
//   s_rdata/s_ready               per-slave read data (slice i = slave i) and completion
//   err/err_clr                   sticky decode/timeout error flag and its clear
module iob_cpu_bus_demux #(
   parameter int                 ADDR_W   = 32,
   parameter int                 DATA_W   = 32,
   parameter int                 N_SLAVES = 4,
   parameter int                 SEL_W    = 2,
   parameter int                 BOOT_SEL = 1,
   parameter int                 TIMEOUT  = 255,
   parameter logic [DATA_W-1:0]  ERR_DATA = 32'hDEADBEEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         boot,
   input  logic                         m_valid,
   input  logic [ADDR_W-1:0]            m_addr,
   input  logic [DATA_W-1:0]            m_wdata,
   input  logic [DATA_W/8-1:0]          m_wstrb,
   output logic [DATA_W-1:0]            m_rdata,
   output logic                         m_ready,
   output logic [N_SLAVES-1:0]          s_valid,
   output logic [ADDR_W-1:0]            s_addr,
   output logic [DATA_W-1:0]            s_wdata,
   output logic [DATA_W/8-1:0]          s_wstrb,
   input  logic [N_SLAVES*DATA_W-1:0]   s_rdata,
   input  logic [N_SLAVES-1:0]          s_ready,
   output logic                         err,
   input  logic                         err_clr
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   // Counter only has to reach TIMEOUT-1; with the watchdog disabled it
   // still counts but simply saturates.
   localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [1:0]          state;
   logic [CNT_W-1:0]    cnt;

   logic [SEL_W-1:0]    sel_raw;
   logic [SEL_W-1:0]    sel_eff;
   logic                dec_err;
   logic [N_SLAVES-1:0] sel_onehot;
   logic                hit;
   logic [DATA_W-1:0]   rdata_mux;

   // Slave select with boot remap of index 0.
   assign sel_raw    = m_addr[ADDR_W-1 -: SEL_W];
   assign sel_eff    = (boot && (sel_raw == '0)) ? SEL_W'(BOOT_SEL) : sel_raw;
   // Widened compare so the check stays meaningful when 2**SEL_W > N_SLAVES.
   assign dec_err    = 32'(sel_eff) >= 32'(N_SLAVES);
   assign sel_onehot = N_SLAVES'(1) << sel_eff;

   // The registered one-hot s_valid is the latched select: it qualifies
   // s_ready and steers the read-data mux, so other slaves are ignored
   // and nothing is accepted once s_valid has dropped.
   assign hit = |(s_ready & s_valid);

   always_comb begin
      rdata_mux = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (s_valid[i]) begin
            rdata_mux = rdata_mux | s_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         m_ready <= 1'b0;
         m_rdata <= '0;
         s_valid <= '0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_wstrb <= '0;
         err     <= 1'b0;
      end else begin
         m_ready <= 1'b0;
         // Clear first so an error set later in this block takes priority.
         if (err_clr) begin
            err <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (m_valid) begin
                  s_addr  <= m_addr;
                  s_wdata <= m_wdata;
                  s_wstrb <= m_wstrb;
                  if (dec_err) begin
                     state   <= RESP;
                     m_ready <= 1'b1;
                     m_rdata <= ERR_DATA;
                     err     <= 1'b1;
                  end else begin
                     state   <= ACCESS;
                     s_valid <= sel_onehot;
                     cnt     <= '0;
                  end
               end
            end

            ACCESS: begin
               if (hit) begin
                  // Captured for writes as well; the master ignores it.
                  m_rdata <= rdata_mux;
                  m_ready <= 1'b1;
                  s_valid <= '0;
                  state   <= RESP;
               end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                  m_rdata <= ERR_DATA;
                  m_ready <= 1'b1;
                  err     <= 1'b1;
                  s_valid <= '0;
                  state   <= RESP;
               end else if (cnt != {CNT_W{1'b1}}) begin
                  cnt <= cnt + 1'b1;
               end
            end

            RESP: begin
               // m_ready is high during this cycle only; m_valid is not
               // looked at here, IDLE samples it again.
               state <= IDLE;
            end

            default: begin
               state   <= IDLE;
               s_valid <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iob_cpu_bus_demux.sv
module tb_iob_cpu_bus_demux;

   localparam int NS = 3;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      logic        err;
      logic [2:0]  sv;
      int          sv_cyc;
      int          done;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            boot = 1'b0;
   logic            m_valid = 1'b0;
   logic [31:0]     m_addr = '0;
   logic [31:0]     m_wdata = '0;
   logic [3:0]      m_wstrb = '0;
   logic [31:0]     m_rdata;
   logic            m_ready;
   logic [NS-1:0]   s_valid;
   logic [31:0]     s_addr;
   logic [31:0]     s_wdata;
   logic [3:0]      s_wstrb;
   logic [NS*32-1:0] s_rdata = '0;
   logic [NS-1:0]   s_ready;
   logic            err;
   logic            err_clr = 1'b0;

   int        n_cmp = 0;
   int        n_err = 0;
   int        cyc = 0;
   int        slv_wait = 0;
   bit        never_ready = 1'b0;
   logic [NS-1:0] spur = '0;
   int        wcnt = 0;
   int        sv_cnt = 0;
   logic [NS-1:0] sv_pat = '0;
   exp_t      q[$];

   iob_cpu_bus_demux #(
      .N_SLAVES (NS),
      .TIMEOUT  (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .boot    (boot),
      .m_valid (m_valid),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_wstrb (m_wstrb),
      .m_rdata (m_rdata),
      .m_ready (m_ready),
      .s_valid (s_valid),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_wstrb (s_wstrb),
      .s_rdata (s_rdata),
      .s_ready (s_ready),
      .err     (err),
      .err_clr (err_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Slave responder: ready after slv_wait wait cycles; non-selected
   // slaves may assert a spurious ready that the DUT must ignore.
   initial begin
      s_ready = '0;
      forever begin
         @(negedge clk);
         if (s_valid != '0) begin
            if (!never_ready && wcnt == slv_wait) begin
               s_ready = s_valid;
            end else begin
               s_ready = spur & ~s_valid;
               wcnt++;
            end
         end else begin
            s_ready = '0;
            wcnt = 0;
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            sv_cnt = 0;
            sv_pat = '0;
         end else begin
            if (s_valid != '0) begin
               if (sv_cnt == 0 && q.size() > 0) begin
                  check("s_addr",  s_addr,  q[0].addr);
                  check("s_wdata", s_wdata, q[0].wdata);
                  check("s_wstrb", s_wstrb, q[0].wstrb);
               end
               sv_cnt++;
               sv_pat = s_valid;
            end
            if (m_ready) begin
               if (q.size() == 0) begin
                  check("spurious_m_ready", 1, 0);
               end else begin
                  e = q.pop_front();
                  check("m_rdata",   m_rdata, e.rdata);
                  check("err",       err,     e.err);
                  check("s_valid_pat", sv_pat, e.sv);
                  check("s_valid_cycles", sv_cnt, e.sv_cyc);
                  check("latency_cycle", cyc, e.done);
               end
               sv_cnt = 0;
               sv_pat = '0;
            end
         end
      end
   end

   task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic b, input bit chained, input bit keep, input bit flip,
                         input logic [31:0] rdata, input logic e, input logic [2:0] sv,
                         input int svc, input int lat);
      exp_t x;
      bit   seen;
      if (!chained) @(negedge clk);
      boot    = b;
      m_valid = 1'b1;
      m_addr  = addr;
      m_wdata = wdata;
      m_wstrb = wstrb;
      x.addr = addr; x.wdata = wdata; x.wstrb = wstrb; x.rdata = rdata;
      x.err = e; x.sv = sv; x.sv_cyc = svc;
      x.done = cyc + (chained ? 1 : 0) + lat;
      q.push_back(x);
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         if (flip && i == 0) boot = ~boot;
         if (m_ready) seen = 1'b1;
      end
      if (!seen) check("m_ready_wait_expired", 0, 1);
      if (!keep) m_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_m_ready"}, m_ready, 0);
      check({pfx, "_m_rdata"}, m_rdata, 0);
      check({pfx, "_s_valid"}, s_valid, 0);
      check({pfx, "_s_addr"},  s_addr,  0);
      check({pfx, "_s_wdata"}, s_wdata, 0);
      check({pfx, "_s_wstrb"}, s_wstrb, 0);
      check({pfx, "_err"},     err,     0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: got expired expected done");
      $fatal(1);
   end

   initial begin
      s_rdata[0*32 +: 32] = 32'h0A0A_0000;
      s_rdata[1*32 +: 32] = 32'h1111_0001;
      s_rdata[2*32 +: 32] = 32'h1234_5678;

      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Read slave 2, 3 wait cycles, other slaves raise spurious ready.
      slv_wait = 3; spur = 3'b011;
      do_req(32'h8000_0010, 32'h0, 4'b0000, 1'b0, 0, 0, 0,
             32'h1234_5678, 1'b0, 3'b100, 4, 5);
      spur = '0;

      // Zero-wait write to slave 1; read data is captured anyway.
      slv_wait = 0;
      do_req(32'h4000_0004, 32'hA5A5_5A5A, 4'b0011, 1'b0, 0, 0, 0,
             32'h1111_0001, 1'b0, 3'b010, 1, 2);

      // Boot remap of slave 0; boot flips mid-access and must not matter.
      slv_wait = 1;
      do_req(32'h0000_0000, 32'h0, 4'b0000, 1'b1, 0, 0, 1,
             32'h1111_0001, 1'b0, 3'b010, 2, 3);
      do_req(32'h0000_0000, 32'h0, 4'b0000, 1'b0, 0, 0, 0,
             32'h0A0A_0000, 1'b0, 3'b001, 2, 3);

      // Back-to-back: m_valid held high across the first m_ready.
      slv_wait = 0;
      do_req(32'h0000_0100, 32'h0, 4'b0000, 1'b0, 0, 1, 0,
             32'h0A0A_0000, 1'b0, 3'b001, 1, 2);
      slv_wait = 2;
      do_req(32'h8000_0020, 32'h0, 4'b0000, 1'b0, 1, 0, 0,
             32'h1234_5678, 1'b0, 3'b100, 3, 4);

      // Watchdog: selected slave silent, the others answer and are ignored.
      never_ready = 1'b1; spur = 3'b101;
      do_req(32'h4000_0000, 32'h0, 4'b0000, 1'b0, 0, 0, 0,
             32'hDEAD_BEEF, 1'b1, 3'b010, 8, 9);
      never_ready = 1'b0; spur = '0;
      repeat (3) @(negedge clk);
      check("err_sticky", err, 1);
      pulse_clr();
      check("err_cleared", err, 0);

      // Decode error with err_clr held high: the set must win.
      err_clr = 1'b1;
      do_req(32'hC000_0000, 32'h0, 4'b0000, 1'b0, 0, 0, 0,
             32'hDEAD_BEEF, 1'b1, 3'b000, 0, 1);
      @(negedge clk);
      err_clr = 1'b0;
      check("err_clr_after_decode", err, 0);

      // Reset asserted while the access is outstanding.
      never_ready = 1'b1;
      @(negedge clk);
      m_valid = 1'b1; m_addr = 32'h8000_0000; m_wstrb = 4'b0000;
      repeat (3) @(negedge clk);
      check("pre_reset_s_valid", s_valid, 3'b100);
      rst = 1'b0;
      m_valid = 1'b0;
      #1;
      check_reset_vals("midrst");
      repeat (2) @(negedge clk);
      check("midrst_no_ready", m_ready, 0);
      rst = 1'b1;
      never_ready = 1'b0;
      slv_wait = 0;
      do_req(32'h0000_0040, 32'h0, 4'b0000, 1'b0, 0, 0, 0,
             32'h0A0A_0000, 1'b0, 3'b001, 1, 2);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/iob_cpu_bus_demux.md
Name: iob_cpu_bus_demux

Overview:
- Parametrised successor to the single-CPU instruction/data bus split.
- Takes one CPU native memory interface (valid/addr/wdata/wstrb -> rdata/ready) and routes each transaction to one of N_SLAVES peripheral ports, selected by address MSBs.
- Adds a boot-time remap of slave 0, registered request and response stages, a per-access timeout watchdog, and an address-decode error path.
- Sits between the CPU wrapper data/instruction buses and the memory/peripheral interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb is DATA_W/8 bits.
- N_SLAVES, 4, number of slave ports, 2..16.
- SEL_W, 2, address MSBs used for selection: sel = addr[ADDR_W-1 -: SEL_W].
- BOOT_SEL, 1, slave index that replaces index 0 while boot=1.
- TIMEOUT, 255, cycles to wait for s_ready; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF, rdata returned on an error response.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- boot  in  1  boot mode; sampled only at request capture.
- m_valid  in  1  CPU request valid.
- m_addr  in  ADDR_W  CPU address.
- m_wdata  in  DATA_W  write data.
- m_wstrb  in  DATA_W/8  byte strobes; all zero means read.
- m_rdata  out  DATA_W  read data, registered.
- m_ready  out  1  one-cycle completion pulse.
- s_valid  out  N_SLAVES  one-hot slave request.
- s_addr  out  ADDR_W  latched address, broadcast to all slaves.
- s_wdata  out  DATA_W  latched write data, broadcast.
- s_wstrb  out  DATA_W/8  latched strobes, broadcast.
- s_rdata  in  N_SLAVES*DATA_W  slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- s_ready  in  N_SLAVES  slave completion.
- err  out  1  sticky error flag.
- err_clr  in  1  clears err.

Behaviour:
- Reset (rst=0, asynchronous) drives:
  - state=IDLE; m_ready=0; m_rdata=0; s_valid=0; s_addr/s_wdata/s_wstrb=0; err=0; timeout counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On m_valid=1, latch addr/wdata/wstrb into the s_* registers.
  - Compute sel from the address MSBs; if boot=1 and sel==0, sel=BOOT_SEL. Latch sel.
  - If sel>=N_SLAVES: go to RESP with decode error.
  - Otherwise go to ACCESS and clear the counter.
- ACCESS:
  - s_valid[sel]=1; all other s_valid bits are 0.
  - s_ready is qualified by sel only; s_ready from non-selected slaves is ignored.
  - On s_ready[sel]=1: capture s_rdata slice sel into m_rdata (captured for writes too), deassert s_valid next cycle, go to RESP.
  - Otherwise, if TIMEOUT!=0 and counter==TIMEOUT-1: go to RESP with timeout error.
  - Otherwise increment the counter; it saturates, never wraps.
- RESP:
  - m_ready=1 for exactly one cycle, then go to IDLE.
  - On error: m_rdata=ERR_DATA and err is set.
- Latency:
  - Minimum m_valid-to-m_ready is 2 cycles (capture, then zero-wait slave ready), i.e. m_ready is asserted in the 3rd cycle.
  - Each slave wait cycle adds 1.
- Master handshake:
  - Master holds m_valid and its request stable until m_ready, and may drop m_valid in the cycle after m_ready.
  - m_valid seen in RESP is ignored; IDLE re-samples it.
  - A master that keeps m_valid high after m_ready issues a new transaction; this is legal for back-to-back requests.
- s_addr/s_wdata/s_wstrb stay stable for the whole ACCESS state.
- boot changing mid-transaction does not affect the latched sel.
- err_clr and an error set in the same cycle: set wins.
- Timeout with a late s_ready: a s_ready arriving after the transition to RESP is ignored.
- Reset asserted mid-ACCESS: s_valid drops asynchronously and no m_ready is issued.

Test Plan:
- Read slave 2 (addr=32'h8000_0010, wstrb=0), slave returns ready after 3 wait cycles with rdata=32'h1234_5678 -> s_valid=4'b0100 for 4 cycles, m_rdata=32'h1234_5678, m_ready single pulse 5 cycles after m_valid.
- Write to addr=32'h4000_0004, wstrb=4'b0011, wdata=32'hA5A5_5A5A, zero-wait slave -> s_valid[1] for 1 cycle, s_wstrb=4'b0011, m_ready 2 cycles after m_valid, err=0.
- boot=1, read addr=32'h0000_0000 -> s_valid=4'b0010 (BOOT_SEL). Repeat with boot=0 -> s_valid=4'b0001.
- Watchdog: TIMEOUT=8, slave never ready -> s_valid held 8 cycles, m_ready with m_rdata=32'hDEADBEEF, err=1 until err_clr pulse, then err=0.
- Decode error: N_SLAVES=3, addr=32'hC000_0000 -> no s_valid bit asserted, m_ready 1 cycle after capture, m_rdata=32'hDEADBEEF, err=1.
- Back-to-back plus mid-access reset: two consecutive reads complete with no lost or duplicated m_ready. Then drive rst=0 during ACCESS -> all outputs return to reset values immediately, and the next request after release completes normally.
